// File: rtl/mlp_seq_engine.sv
// Time-multiplexed N-layer fully connected network on a single signed fixed-point MAC.
// Inputs and outputs stream over valid/ready; biases and weights come from an external weight ROM.
module mlp_seq_engine #(
    parameter int DATA_W      = 32,
    parameter int FRAC_BITS   = 16,
    parameter int NUM_LAYERS  = 3,
    parameter int IN_SIZE     = 4,
    parameter int HID_SIZE    = 4,
    parameter int OUT_SIZE    = 2,
    parameter int RELU_HIDDEN = 1,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              w_rd,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              busy,
    output logic              sat_flag
);

    localparam int MAX_IH = (IN_SIZE > HID_SIZE) ? IN_SIZE : HID_SIZE;
    localparam int BUF_N  = (MAX_IH > OUT_SIZE) ? MAX_IH : OUT_SIZE;
    localparam int IDX_W  = (BUF_N > 1) ? $clog2(BUF_N) : 1;
    localparam int CNT_W  = $clog2(BUF_N + 4);
    localparam int LAY_W  = $clog2(NUM_LAYERS + 1);
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + 8;
    // Layer l writes buffer !l[0], so the final layer's parity fixes where results live.
    localparam bit U_BUF  = ((NUM_LAYERS - 1) % 2) == 0;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;
    state_t state_reg, state_next;

    logic [CNT_W-1:0]        k_reg, ph_reg, neuron_reg, j_reg;
    logic [LAY_W-1:0]        layer_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic                    sat_reg;

    logic [CNT_W-1:0]         n_in, n_out;
    logic                     last_layer, last_neuron, last_j, src_buf, issue, wb, clamp;
    logic signed [DATA_W-1:0] act_q, sat_val, wb_data;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  shifted, acc_add, bias_acc;

    logic [1:0]         buf_we;
    logic [IDX_W-1:0]   buf_waddr, rd_addr;
    logic [DATA_W-1:0]  buf_wdata;

    // Ping/pong activation buffers; write-first read port so a same-cycle write is seen.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_buf
            logic [DATA_W-1:0] mem [BUF_N];
            logic [DATA_W-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (buf_we[gi]) mem[buf_waddr] <= buf_wdata;
                if (buf_we[gi] && buf_waddr == rd_addr) rd_q <= buf_wdata;
                else                                     rd_q <= mem[rd_addr];
            end
        end
    endgenerate

    always_comb begin
        last_layer  = (layer_reg == LAY_W'(NUM_LAYERS - 1));
        n_in        = (layer_reg == '0) ? CNT_W'(IN_SIZE) : CNT_W'(HID_SIZE);
        n_out       = last_layer ? CNT_W'(OUT_SIZE) : CNT_W'(HID_SIZE);
        last_neuron = (neuron_reg == n_out - CNT_W'(1));
        last_j      = (j_reg == CNT_W'(OUT_SIZE - 1));
        src_buf     = layer_reg[0];
        issue       = (state_reg == S_COMPUTE) && (ph_reg <= n_in);
        wb          = (state_reg == S_COMPUTE) && (ph_reg == n_in + CNT_W'(2));
        act_q       = src_buf ? g_buf[1].rd_q : g_buf[0].rd_q;
        prod        = $signed(w_data) * act_q;
        acc_add     = acc_reg + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        bias_acc    = {{(ACC_W-DATA_W-FRAC_BITS){w_data[DATA_W-1]}}, w_data, {FRAC_BITS{1'b0}}};
        shifted     = acc_reg >>> FRAC_BITS;
        clamp       = (shifted > SAT_MAX) || (shifted < SAT_MIN);
        if (shifted > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
        else if (shifted < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
        else                        sat_val = shifted[DATA_W-1:0];
        // ReLU follows saturation and never touches the final linear layer.
        wb_data = (RELU_HIDDEN != 0 && !last_layer && sat_val[DATA_W-1]) ? '0 : sat_val;
    end

    always_comb begin
        buf_we    = '0;
        buf_waddr = '0;
        buf_wdata = in_data;
        rd_addr   = '0;
        if (state_reg == S_LOAD && in_valid) begin
            buf_we[0] = 1'b1;
            buf_waddr = IDX_W'(k_reg);
        end
        if (wb) begin
            if (src_buf) buf_we[0] = 1'b1;
            else         buf_we[1] = 1'b1;
            buf_waddr = IDX_W'(neuron_reg);
            buf_wdata = wb_data;
        end
        // Activation i is fetched one cycle ahead so it meets weight i in the MAC.
        if (state_reg == S_COMPUTE && ph_reg >= CNT_W'(1) && ph_reg <= n_in)
            rd_addr = IDX_W'(ph_reg - CNT_W'(1));
        else if (state_reg == S_UNLOAD)
            rd_addr = (out_ready && !last_j) ? IDX_W'(j_reg + CNT_W'(1)) : IDX_W'(j_reg);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_LOAD;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        w_rd       = issue;
        w_addr     = addr_reg;
        sat_flag   = sat_reg;
        out_data   = U_BUF ? g_buf[1].rd_q : g_buf[0].rd_q;
        case (state_reg)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && k_reg == CNT_W'(IN_SIZE - 1)) state_next = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (wb && last_neuron && last_layer) state_next = S_UNLOAD;
            end
            S_UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && last_j) state_next = S_LOAD;
            end
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_reg      <= '0;
            ph_reg     <= '0;
            neuron_reg <= '0;
            j_reg      <= '0;
            layer_reg  <= '0;
            addr_reg   <= '0;
            acc_reg    <= '0;
            sat_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_LOAD: begin
                    if (in_valid) begin
                        if (k_reg == '0) sat_reg <= 1'b0;
                        if (k_reg == CNT_W'(IN_SIZE - 1)) begin
                            k_reg      <= '0;
                            ph_reg     <= '0;
                            neuron_reg <= '0;
                            layer_reg  <= '0;
                            addr_reg   <= '0;
                        end else begin
                            k_reg <= k_reg + CNT_W'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (issue) addr_reg <= addr_reg + ADDR_W'(1);
                    if (ph_reg == CNT_W'(1))
                        acc_reg <= bias_acc;
                    else if (ph_reg >= CNT_W'(2) && ph_reg <= n_in + CNT_W'(1))
                        acc_reg <= acc_add;
                    if (wb) begin
                        ph_reg <= '0;
                        if (clamp) sat_reg <= 1'b1;
                        if (last_neuron) begin
                            neuron_reg <= '0;
                            layer_reg  <= layer_reg + LAY_W'(1);
                        end else begin
                            neuron_reg <= neuron_reg + CNT_W'(1);
                        end
                    end else begin
                        ph_reg <= ph_reg + CNT_W'(1);
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) j_reg <= last_j ? '0 : j_reg + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_seq_engine.sv
// Directed bench for mlp_seq_engine: a ReLU instance and a linear twin share stimulus and weight ROM.
module tb_mlp_seq_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, w_rd, busy, sat_flag;
    logic [31:0] out_data, w_data;
    logic [15:0] w_addr;
    logic        in_ready_l, out_valid_l, w_rd_l, busy_l, sat_l;
    logic [31:0] out_data_l, w_data_l;
    logic [15:0] w_addr_l;

    logic [31:0] wmem [0:63];
    int n_chk = 0;
    int n_err = 0;
    int rd_cnt = 0;
    int addr_bad = 0;
    int rd_base = 0;
    int bad_base = 0;

    always #5 clk = ~clk;

    mlp_seq_engine #(.RELU_HIDDEN(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data), .busy(busy), .sat_flag(sat_flag)
    );

    mlp_seq_engine #(.RELU_HIDDEN(0)) u_dut_lin (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
        .w_rd(w_rd_l), .w_addr(w_addr_l), .w_data(w_data_l), .busy(busy_l), .sat_flag(sat_l)
    );

    // Weight ROM with one cycle read latency.
    always @(posedge clk) begin
        w_data   <= wmem[w_addr[5:0]];
        w_data_l <= wmem[w_addr_l[5:0]];
    end

    always @(posedge clk) begin
        if (rst && w_rd) begin
            if (w_addr != 16'(rd_cnt - rd_base)) addr_bad <= addr_bad + 1;
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_w();
        for (int i = 0; i < 64; i++) wmem[i] = '0;
    endtask

    task automatic identity_w();
        clear_w();
        for (int n = 0; n < 4; n++) begin
            wmem[5*n + 1 + n]      = 32'h0001_0000;
            wmem[20 + 5*n + 1 + n] = 32'h0001_0000;
        end
        for (int j = 0; j < 2; j++) wmem[40 + 5*j + 1 + j] = 32'h0001_0000;
    endtask

    task automatic send_vec(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] v3, input logic sat_pre, input logic hold);
        logic [31:0] v [4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        rd_base  = rd_cnt;
        bad_base = addr_bad;
        @(negedge clk);
        chk("in_ready_load", in_ready, 1);
        chk("sat_pre", sat_flag, sat_pre);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            @(negedge clk);
            if (i == 0) chk("sat_clr", sat_flag, 0);
        end
        if (hold) in_data = 32'hDEAD_BEEF;
        else      in_valid = 1'b0;
    endtask

    task automatic finish_vec(input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] l0,
                              input logic [31:0] l1, input logic exp_sat, input int stall);
        int cyc;
        int busy_low;
        int hold_err;
        logic [31:0] held;
        cyc = 1;
        busy_low = 0;
        hold_err = 0;
        chk("in_ready_busy", in_ready, 0);
        while (!out_valid && cyc < 300) begin
            if (!busy) busy_low++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk("latency", cyc, 71);
        chk("busy_hi", busy_low, 0);
        chk("sat_flag", sat_flag, exp_sat);
        chk("sat_lin", sat_l, exp_sat);
        held = out_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!out_valid || out_data !== held) hold_err++;
        end
        chk("stall_hold", hold_err, 0);
        out_ready = 1'b1;
        chk("out0", out_data, e0);
        chk("lin0", out_data_l, l0);
        @(negedge clk);
        chk("out1_valid", out_valid, 1);
        chk("out1", out_data, e1);
        chk("lin1", out_data_l, l1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_off", out_valid, 0);
        chk("rd_count", rd_cnt - rd_base, 50);
        chk("rd_order", addr_bad - bad_base, 0);
        $display("vec out %h %h lin %h %h sat %0d lat %0d", e0, e1, l0, l1, exp_sat, cyc);
    endtask

    initial begin
        int partial;
        clear_w();
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_w_rd", w_rd, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sat", sat_flag, 0);
        #20;
        @(negedge clk);
        rst = 1'b1;

        // Zero weights, final biases 1.0; in_valid held high with junk during compute.
        wmem[40] = 32'h0001_0000;
        wmem[45] = 32'h0001_0000;
        send_vec(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b0, 1'b1);
        finish_vec(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 0);

        // Identity network: ReLU clips -1.0, linear twin keeps it; 5-cycle stall at unload.
        identity_w();
        send_vec(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0, 1'b0, 1'b0);
        finish_vec(32'h0002_0000, 32'h0, 32'h0002_0000, 32'hFFFF_0000, 1'b0, 5);

        // Layer-0 overflow saturates; flag persists until next first accept.
        clear_w();
        for (int n = 0; n < 4; n++)
            for (int i = 0; i < 4; i++) wmem[5*n + 1 + i] = 32'h7FFF_0000;
        send_vec(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0, 1'b0);
        finish_vec(32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0);
        send_vec(32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        finish_vec(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 0);

        // Reset pulse at compute cycle 30, then a clean rerun.
        identity_w();
        send_vec(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0, 1'b0, 1'b0);
        repeat (29) @(negedge clk);
        chk("pre_rst_w_rd", w_rd, 1);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_w_rd", w_rd, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_w_addr", w_addr, 0);
        chk("arst_lin_w_rd", w_rd_l, 0);
        @(negedge clk);
        rst = 1'b1;
        partial = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid || out_valid_l || busy) partial++;
        end
        chk("no_partial", partial, 0);
        send_vec(32'h0002_0000, 32'hFFFF_0000, 32'h0000_8000, 32'h0, 1'b0, 1'b0);
        finish_vec(32'h0002_0000, 32'h0, 32'h0002_0000, 32'hFFFF_0000, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mlp_seq_engine.md
Name: mlp_seq_engine

Overview:
- Parametrised successor to the fixed two-layer MLP: an N-layer fully connected network (NUM_LAYERS >= 2) evaluated on a single time-multiplexed signed fixed-point MAC.
- Input vectors stream in and output vectors stream out over valid/ready.
- Bias and weight words are fetched sequentially from an external read-only weight memory.
- Hidden layers optionally apply ReLU; the last layer is linear.

Parameters:
- DATA_W, 32, width of activations, weights and biases (signed two's complement).
- FRAC_BITS, 16, fractional bits of the fixed-point format (Q(DATA_W-FRAC_BITS).FRAC_BITS).
- NUM_LAYERS, 3, number of linear layers (>= 2).
- IN_SIZE, 4, input vector length.
- HID_SIZE, 4, width of every hidden layer.
- OUT_SIZE, 2, output vector length.
- RELU_HIDDEN, 1, 1 = ReLU after every non-final layer.
- ADDR_W, 16, weight memory address width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  engine accepts an input word.
- in_data  input  DATA_W  input element, index order 0..IN_SIZE-1.
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts an output word.
- out_data  output  DATA_W  output element, index order 0..OUT_SIZE-1.
- w_rd  output  1  weight memory read strobe.
- w_addr  output  ADDR_W  weight memory word address.
- w_data  input  DATA_W  read data, valid exactly 1 cycle after w_rd.
- busy  output  1  high in COMPUTE and UNLOAD.
- sat_flag  output  1  sticky: some neuron saturated during the current inference.

Behaviour:
- Reset (rst low, asynchronous): state LOAD, all counters 0, in_ready=1, out_valid=0, w_rd=0, w_addr=0, busy=0, sat_flag=0. Buffer contents are don't-care.
- FSM states:
  - LOAD: in_ready=1; each in_valid&in_ready stores in_data into the ping buffer at index k, k++. After the word with k=IN_SIZE-1 is accepted -> COMPUTE. Accepting k=0 clears sat_flag.
  - COMPUTE: in_ready=0, busy=1. Layers run in order; layer l has n_in inputs (IN_SIZE for l=0, HID_SIZE otherwise) and n_out outputs (OUT_SIZE for the last layer, HID_SIZE otherwise). Each neuron takes exactly n_in+3 cycles:
    - n_in+1 issue cycles with w_rd=1.
    - 1 drain cycle.
    - 1 writeback cycle with w_rd=0.
    - Neurons are not overlapped.
  - UNLOAD: out_valid=1 with out_data = result[j]. j advances on out_valid&out_ready. After j=OUT_SIZE-1 is taken -> LOAD; in_ready may be high on the next cycle.
- Weight layout:
  - Flat and contiguous from address 0.
  - Per neuron: bias word, then weights for inputs 0..n_in-1. Neurons follow in order, then layers in order.
  - w_addr increments by 1 per issue and resets to 0 on entry to COMPUTE.
  - Total words = sum over layers of n_out*(n_in+1). Defaults give 20+20+10=50, so the last address is 49.
- Arithmetic:
  - Accumulator is signed, 2*DATA_W+8 bits, initialised to bias <<< FRAC_BITS.
  - Each w_data*act product is a full 2*DATA_W signed result, accumulated without intermediate rounding.
  - At writeback: acc >>> FRAC_BITS (arithmetic, truncation toward -inf), then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. Any clamp sets sat_flag.
  - If RELU_HIDDEN=1 and the layer is not the last, negative results are written as 0. ReLU applies after saturation.
- Buffering:
  - Two activation buffers of max(IN_SIZE,HID_SIZE) entries (ping/pong).
  - Layer l reads one buffer and writes the other; roles swap per layer.
  - UNLOAD reads the buffer written by the last layer.
- Latency:
  - Last input accept to first out_valid = 1 + sum over layers n_out*(n_in+3) cycles. Defaults: 1+28+28+14 = 71 cycles.
- Boundaries:
  - in_valid during COMPUTE/UNLOAD is ignored; in_ready=0.
  - out_ready held low stalls UNLOAD indefinitely; out_data stays stable while out_valid&!out_ready.
  - out_valid&out_ready on the last word and in_valid on the next cycle are accepted with no bubble beyond the state change.
  - Reset mid-COMPUTE or mid-UNLOAD aborts immediately: out_valid=0, w_rd=0 in the same cycle. No partial output is emitted afterwards.
  - sat_flag stays visible through UNLOAD and until the next inference's first input accept.

Test Plan:
- All weights 0; hidden biases 0; final biases 0x00010000. Input [1,2,3,4].0 -> out [0x00010000, 0x00010000]; sat_flag=0; 50 reads, addresses 0..49 in order.
- Hidden weights identity (1.0 on diagonal), biases 0; final weights row j = 1.0 on input j. Input [0x00020000, 0xFFFF0000, 0x00008000, 0] -> out [0x00020000, 0] (ReLU clips -1.0); with RELU_HIDDEN=0 -> [0x00020000, 0xFFFF0000].
- Inputs 0x7FFF0000 and all layer-0 weights 0x7FFF0000 -> layer-0 results clamp to 0x7FFFFFFF; sat_flag=1 at first out_valid. The next inference with zero inputs clears it on the first accept.
- Default config: exactly 71 cycles from the 4th input accept to out_valid rising; busy high throughout.
- out_ready low for 5 cycles at UNLOAD start -> out_valid held, out_data unchanged. Then two back-to-back accepts, in_ready=1 on the following cycle.
- rst low for 1 cycle at compute cycle 30 -> outputs return to reset values asynchronously. A fresh inference then produces the same result as an undisturbed run.
